// File: rtl/data_types.sv
// ==========================================================================
// data_types : shared operand, CDB and reservation-station entry types
// Revision   : 1.0
// ==========================================================================
`default_nettype none

package data_types;

  typedef logic [31:0] word32_t;

  typedef enum logic [1:0] {
    SLL = 2'd0,
    SRL = 2'd1,
    SRA = 2'd2
  } shift_op_t;

  // Producer tags of every functional-unit result slot that can hit the CDB.
  typedef enum logic [2:0] {
    ALU_0 = 3'd0,
    ALU_1 = 3'd1,
    ALU_2 = 3'd2,
    MUL_0 = 3'd3,
    MUL_1 = 3'd4,
    SHF_0 = 3'd5,
    SHF_1 = 3'd6,
    LSU_0 = 3'd7
  } rs_tag_t;

  typedef struct packed {
    logic    valid;
    rs_tag_t tag;
    word32_t val;
  } cdb_t;

  typedef struct packed {
    logic    rdy;
    rs_tag_t tag;
    word32_t val;
  } rs_operand_t;

  typedef struct packed {
    logic        busy;
    shift_op_t   oper;
    rs_operand_t rs1;
    rs_operand_t rs2;
  } shift_rs_entry_t;

  function automatic logic cdb_hit(input cdb_t cdb, input rs_tag_t tag);
    return cdb.valid && (cdb.tag == tag);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rs_operand_capture.sv
// ==========================================================================
// rs_operand_capture : one operand slot with dispatch write, CDB snoop, bypass
// Revision           : 1.0
// ==========================================================================
`default_nettype none

module rs_operand_capture
  import data_types::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        disp_we_i,
  input  logic        busy_i,
  input  rs_operand_t disp_opnd_i,
  input  cdb_t        cdb_i,
  output rs_operand_t opnd_o
);

  rs_operand_t opnd_q;
  rs_operand_t opnd_d;

  always_comb begin
    opnd_d = opnd_q;
    if (disp_we_i) begin
      opnd_d = disp_opnd_i;
      // Bypass: a broadcast in the dispatch cycle would otherwise be missed.
      if (!disp_opnd_i.rdy && cdb_hit(cdb_i, disp_opnd_i.tag)) begin
        opnd_d.rdy = 1'b1;
        opnd_d.val = cdb_i.val;
      end
    end else if (busy_i && !opnd_q.rdy && cdb_hit(cdb_i, opnd_q.tag)) begin
      opnd_d.rdy = 1'b1;
      opnd_d.val = cdb_i.val;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      opnd_q <= '0;
    end else begin
      opnd_q <= opnd_d;
    end
  end

  assign opnd_o = opnd_q;

endmodule

`default_nettype wire

// File: rtl/shift_rs.sv
// ==========================================================================
// shift_rs : reservation station feeding the shifter, one issue per cycle
// Revision : 1.0
// ==========================================================================
`default_nettype none

module shift_rs
  import data_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      flush_i,
  input  logic      disp_valid_i,
  output logic      disp_ready_o,
  input  shift_op_t disp_oper_i,
  input  logic      disp_rs1_rdy_i,
  input  rs_tag_t   disp_rs1_tag_i,
  input  word32_t   disp_rs1_val_i,
  input  logic      disp_rs2_rdy_i,
  input  rs_tag_t   disp_rs2_tag_i,
  input  word32_t   disp_rs2_val_i,
  input  cdb_t      cdb_i,
  output shift_op_t oper_o,
  output word32_t   rs1_val_o,
  output word32_t   rs2_val_o,
  output logic      ready_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  shift_op_t        oper_q [DEPTH];
  shift_op_t        oper_d [DEPTH];
  rs_operand_t      rs1_opnd [DEPTH];
  rs_operand_t      rs2_opnd [DEPTH];
  shift_rs_entry_t  entry [DEPTH];

  shift_op_t oper_hold_q, oper_hold_d;
  word32_t   rs1_hold_q, rs1_hold_d;
  word32_t   rs2_hold_q, rs2_hold_d;

  logic             free_vld;
  logic [IDX_W-1:0] free_idx;
  logic             issue_vld;
  logic [IDX_W-1:0] issue_idx;
  logic             disp_fire;
  logic             issue_fire;

  rs_operand_t disp_rs1;
  rs_operand_t disp_rs2;

  assign disp_rs1 = '{rdy: disp_rs1_rdy_i, tag: disp_rs1_tag_i, val: disp_rs1_val_i};
  assign disp_rs2 = '{rdy: disp_rs2_rdy_i, tag: disp_rs2_tag_i, val: disp_rs2_val_i};

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      logic we;
      assign we = disp_fire && (free_idx == IDX_W'(i));

      rs_operand_capture u_rs1 (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .disp_we_i   (we),
        .busy_i      (busy_q[i]),
        .disp_opnd_i (disp_rs1),
        .cdb_i       (cdb_i),
        .opnd_o      (rs1_opnd[i])
      );

      rs_operand_capture u_rs2 (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .disp_we_i   (we),
        .busy_i      (busy_q[i]),
        .disp_opnd_i (disp_rs2),
        .cdb_i       (cdb_i),
        .opnd_o      (rs2_opnd[i])
      );

      assign entry[i] = '{busy: busy_q[i], oper: oper_q[i],
                          rs1: rs1_opnd[i], rs2: rs2_opnd[i]};
    end
  endgenerate

  // Two lowest-index priority encoders; descending scan lets index 0 win.
  always_comb begin
    free_vld  = 1'b0;
    free_idx  = '0;
    issue_vld = 1'b0;
    issue_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!entry[i].busy) begin
        free_vld = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (entry[i].busy && entry[i].rs1.rdy && entry[i].rs2.rdy) begin
        issue_vld = 1'b1;
        issue_idx = IDX_W'(i);
      end
    end
  end

  assign disp_ready_o = free_vld;
  assign disp_fire    = disp_valid_i && free_vld && !flush_i;
  assign issue_fire   = issue_vld && !flush_i;
  assign ready_o      = issue_fire;

  assign oper_o    = issue_vld ? entry[issue_idx].oper    : oper_hold_q;
  assign rs1_val_o = issue_vld ? entry[issue_idx].rs1.val : rs1_hold_q;
  assign rs2_val_o = issue_vld ? entry[issue_idx].rs2.val : rs2_hold_q;

  always_comb begin
    busy_d      = busy_q;
    oper_d      = oper_q;
    oper_hold_d = oper_hold_q;
    rs1_hold_d  = rs1_hold_q;
    rs2_hold_d  = rs2_hold_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      if (issue_fire) begin
        busy_d[issue_idx] = 1'b0;
        oper_hold_d       = entry[issue_idx].oper;
        rs1_hold_d        = entry[issue_idx].rs1.val;
        rs2_hold_d        = entry[issue_idx].rs2.val;
      end
      if (disp_fire) begin
        busy_d[free_idx] = 1'b1;
        oper_d[free_idx] = disp_oper_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q      <= '0;
      oper_hold_q <= SLL;
      rs1_hold_q  <= '0;
      rs2_hold_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        oper_q[i] <= SLL;
      end
    end else begin
      busy_q      <= busy_d;
      oper_hold_q <= oper_hold_d;
      rs1_hold_q  <= rs1_hold_d;
      rs2_hold_q  <= rs2_hold_d;
      for (int i = 0; i < DEPTH; i++) begin
        oper_q[i] <= oper_d[i];
      end
    end
  end

endmodule

`default_nettype wire
